// File: rtl/osnt_stamp_pkg.sv
// ============================================================================
// Module      : osnt_stamp_pkg
// Description : Shared constants and helpers for the OSNT fixed-point
//               timestamp unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package osnt_stamp_pkg;

  // Default geometry of the stamp unit
  localparam int DEF_TS_WIDTH   = 64;
  localparam int DEF_FRAC_WIDTH = 32;
  localparam int DEF_INC_WIDTH  = 40;
  localparam int ACC_WIDTH      = DEF_TS_WIDTH + DEF_FRAC_WIDTH;

  // Increment applied after reset: 1.0 count per cycle
  localparam logic [DEF_INC_WIDTH-1:0] DEF_INCR = 40'h01_0000_0000;

  // Place a signed integer offset into accumulator units. The shifted value
  // fills the accumulator exactly, so the sign bit lands on the accumulator
  // MSB and modulo addition performs the backwards slew for negative inputs.
  function automatic logic [ACC_WIDTH-1:0] adj_to_acc(input logic [DEF_TS_WIDTH-1:0] adj);
    return {adj, {DEF_FRAC_WIDTH{1'b0}}};
  endfunction

endpackage : osnt_stamp_pkg

`default_nettype wire

// File: rtl/stamp_capture_chan.sv
// ============================================================================
// Module      : stamp_capture_chan
// Description : One timestamp capture channel: first-event-wins stamp
//               holding with valid flag and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stamp_capture_chan #(
  parameter int TIMESTAMP_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trig,
  input  logic                       ack,
  input  logic [TIMESTAMP_WIDTH-1:0] stamp_in,
  output logic [TIMESTAMP_WIDTH-1:0] stamp,
  output logic                       valid,
  output logic                       ovf
);

  logic [TIMESTAMP_WIDTH-1:0] stamp_q, stamp_d;
  logic                       valid_q, valid_d;
  logic                       ovf_q,   ovf_d;

  // Next-state: an ack frees the slot so a coincident trigger is accepted;
  // a trigger on an occupied, unacked slot is recorded as lost.
  always_comb begin
    stamp_d = stamp_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (trig) begin
      if (ack) begin
        stamp_d = stamp_in;
        valid_d = 1'b1;
        ovf_d   = 1'b0;
      end else if (!valid_q) begin
        stamp_d = stamp_in;
        valid_d = 1'b1;
      end else begin
        ovf_d   = 1'b1;
      end
    end else if (ack) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      stamp_q <= stamp_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stamp = stamp_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule : stamp_capture_chan

`default_nettype wire

// File: rtl/osnt_stamp_unit.sv
// ============================================================================
// Module      : osnt_stamp_unit
// Description : Fixed-point timestamp accumulator with software set/slew/
//               trim, per-channel capture and coherent snapshot readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module osnt_stamp_unit
  import osnt_stamp_pkg::*;
#(
  parameter int                     TIMESTAMP_WIDTH = DEF_TS_WIDTH,
  parameter int                     FRAC_WIDTH      = DEF_FRAC_WIDTH,
  parameter int                     INC_WIDTH       = DEF_INC_WIDTH,
  parameter logic [INC_WIDTH-1:0]   DEFAULT_INCR    = DEF_INCR,
  parameter int                     NUM_CAPTURE     = 4
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_resetn,
  input  logic [INC_WIDTH-1:0]                   incr_value,
  input  logic                                   incr_wr,
  input  logic [TIMESTAMP_WIDTH-1:0]             set_value,
  input  logic                                   set_wr,
  input  logic [TIMESTAMP_WIDTH-1:0]             adj_value,
  input  logic                                   adj_wr,
  input  logic [NUM_CAPTURE-1:0]                 cap_trig,
  input  logic [NUM_CAPTURE-1:0]                 cap_ack,
  output logic [NUM_CAPTURE*TIMESTAMP_WIDTH-1:0] cap_stamp,
  output logic [NUM_CAPTURE-1:0]                 cap_valid,
  output logic [NUM_CAPTURE-1:0]                 cap_ovf,
  input  logic                                   snap_req,
  output logic [TIMESTAMP_WIDTH-1:0]             snap_value,
  output logic [TIMESTAMP_WIDTH-1:0]             stamp_counter
);

  localparam int ACC_W = TIMESTAMP_WIDTH + FRAC_WIDTH;

  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [INC_WIDTH-1:0]       incr_q, incr_d;
  logic [TIMESTAMP_WIDTH-1:0] snap_q, snap_d;
  logic [ACC_W-1:0]           incr_ext;
  logic [ACC_W-1:0]           adj_ext;

  assign incr_ext = {{(ACC_W-INC_WIDTH){1'b0}}, incr_q};

  // Offset in accumulator units; the package helper covers the default geometry
  if ((TIMESTAMP_WIDTH == DEF_TS_WIDTH) && (FRAC_WIDTH == DEF_FRAC_WIDTH)) begin : g_adj_pkg
    assign adj_ext = adj_to_acc(adj_value);
  end else begin : g_adj_generic
    assign adj_ext = {adj_value, {FRAC_WIDTH{1'b0}}};
  end

  // Next-state: set beats adjust beats free-run; increment/snapshot load independently
  always_comb begin
    acc_d  = acc_q + incr_ext;
    incr_d = incr_q;
    snap_d = snap_q;
    if (set_wr) begin
      acc_d = {set_value, {FRAC_WIDTH{1'b0}}};
    end else if (adj_wr) begin
      acc_d = acc_q + incr_ext + adj_ext;
    end
    if (incr_wr) begin
      incr_d = incr_value;
    end
    if (snap_req) begin
      snap_d = stamp_counter;
    end
  end

  // Accumulator, increment and snapshot registers
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      acc_q  <= '0;
      incr_q <= DEFAULT_INCR;
      snap_q <= '0;
    end else begin
      acc_q  <= acc_d;
      incr_q <= incr_d;
      snap_q <= snap_d;
    end
  end

  assign stamp_counter = acc_q[ACC_W-1:FRAC_WIDTH];
  assign snap_value    = snap_q;

  for (genvar i = 0; i < NUM_CAPTURE; i++) begin : g_chan
    stamp_capture_chan #(
      .TIMESTAMP_WIDTH (TIMESTAMP_WIDTH)
    ) u_chan (
      .clk      (axi_aclk),
      .rst_n    (axi_resetn),
      .trig     (cap_trig[i]),
      .ack      (cap_ack[i]),
      .stamp_in (stamp_counter),
      .stamp    (cap_stamp[i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH]),
      .valid    (cap_valid[i]),
      .ovf      (cap_ovf[i])
    );
  end

endmodule : osnt_stamp_unit

`default_nettype wire

// File: tb/tb_osnt_stamp_unit.sv
// ============================================================================
// Module      : tb_osnt_stamp_unit
// Description : Self-checking bench for osnt_stamp_unit with a behavioural
//               reference model of time, capture channels and snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_osnt_stamp_unit;

  localparam int NC = 4;

  logic           clk = 1'b0;
  logic           axi_resetn;
  logic [39:0]    incr_value;
  logic           incr_wr;
  logic [63:0]    set_value;
  logic           set_wr;
  logic [63:0]    adj_value;
  logic           adj_wr;
  logic [NC-1:0]  cap_trig;
  logic [NC-1:0]  cap_ack;
  logic [NC*64-1:0] cap_stamp;
  logic [NC-1:0]  cap_valid;
  logic [NC-1:0]  cap_ovf;
  logic           snap_req;
  logic [63:0]    snap_value;
  logic [63:0]    stamp_counter;

  int checks = 0;
  int errors = 0;

  // Reference model: time as integer.fraction, capture slots, snapshot
  logic [95:0]    m_acc;
  logic [39:0]    m_incr;
  logic [63:0]    m_cap [NC];
  logic [NC-1:0]  m_valid;
  logic [NC-1:0]  m_ovf;
  logic [63:0]    m_snap;

  always #5 clk = ~clk;

  osnt_stamp_unit dut (
    .axi_aclk      (clk),
    .axi_resetn    (axi_resetn),
    .incr_value    (incr_value),
    .incr_wr       (incr_wr),
    .set_value     (set_value),
    .set_wr        (set_wr),
    .adj_value     (adj_value),
    .adj_wr        (adj_wr),
    .cap_trig      (cap_trig),
    .cap_ack       (cap_ack),
    .cap_stamp     (cap_stamp),
    .cap_valid     (cap_valid),
    .cap_ovf       (cap_ovf),
    .snap_req      (snap_req),
    .snap_value    (snap_value),
    .stamp_counter (stamp_counter)
  );

  task automatic model_reset();
    m_acc   = '0;
    m_incr  = 40'h01_0000_0000;
    m_valid = '0;
    m_ovf   = '0;
    m_snap  = '0;
    for (int i = 0; i < NC; i++) m_cap[i] = '0;
  endtask

  task automatic clear_strobes();
    incr_wr  = 1'b0;
    set_wr   = 1'b0;
    adj_wr   = 1'b0;
    cap_trig = '0;
    cap_ack  = '0;
    snap_req = 1'b0;
  endtask

  // One clock: predict from the current inputs, advance, then drop strobes
  task automatic tick();
    logic [95:0] n_acc;
    logic [39:0] n_incr;
    logic [63:0] n_snap;
    logic [63:0] now;
    now = m_acc[95:32];
    if (set_wr) begin
      n_acc = {set_value, 32'h0};
    end else begin
      n_acc = m_acc + {56'h0, m_incr};
      if (adj_wr) n_acc = n_acc + {adj_value, 32'h0};
    end
    n_incr = incr_wr ? incr_value : m_incr;
    n_snap = snap_req ? now : m_snap;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (cap_trig[i]) begin
        if (!m_valid[i] || cap_ack[i]) begin
          m_cap[i]   = now;
          m_valid[i] = 1'b1;
          if (cap_ack[i]) m_ovf[i] = 1'b0;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end else if (cap_ack[i]) begin
        m_valid[i] = 1'b0;
        m_ovf[i]   = 1'b0;
      end
    end
    m_acc  = n_acc;
    m_incr = n_incr;
    m_snap = n_snap;
    clear_strobes();
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0;
    clear_strobes();
    incr_value = '0;
    set_value  = '0;
    adj_value  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stamp_counter !== 64'd0 || snap_value !== 64'd0 || cap_valid !== '0 ||
        cap_ovf !== '0 || cap_stamp !== '0) begin
      errors++;
      $display("FAIL reset_state: stamp=%h snap=%h valid=%b ovf=%b caps=%h expected all zero",
               stamp_counter, snap_value, cap_valid, cap_ovf, cap_stamp);
    end
    axi_resetn = 1'b1;
    repeat (100) tick();
    checks++;
    if (stamp_counter !== 64'd100 || cap_valid !== '0) begin
      errors++;
      $display("FAIL default_incr_100: stamp=%0d valid=%b expected stamp=100 valid=0",
               stamp_counter, cap_valid);
    end
  endtask

  task automatic test_incr();
    logic [63:0] base;
    incr_value = 40'h00_8000_0000;
    incr_wr    = 1'b1;
    tick();
    base = m_acc[95:32];
    repeat (10) tick();
    checks++;
    if (stamp_counter !== base + 64'd5) begin
      errors++;
      $display("FAIL incr_half: stamp=%0d expected %0d", stamp_counter, base + 64'd5);
    end
    incr_value = 40'h01_8000_0000;
    incr_wr    = 1'b1;
    tick();
    base = m_acc[95:32];
    repeat (4) tick();
    checks++;
    if (stamp_counter !== base + 64'd6) begin
      errors++;
      $display("FAIL incr_one_half: stamp=%0d expected %0d", stamp_counter, base + 64'd6);
    end
    incr_value = 40'h01_0000_0000;
    incr_wr    = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [63:0] exp_seq [3];
    exp_seq[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_seq[1] = 64'h0;
    exp_seq[2] = 64'h1;
    set_value = 64'hFFFF_FFFF_FFFF_FFFE;
    set_wr    = 1'b1;
    tick();
    checks++;
    if (stamp_counter !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL set_latency: stamp=%h expected FFFFFFFFFFFFFFFE", stamp_counter);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (stamp_counter !== exp_seq[k]) begin
        errors++;
        $display("FAIL wrap_step%0d: stamp=%h expected %h", k, stamp_counter, exp_seq[k]);
      end
    end
    set_value = 64'h0123_4567_89AB_CDEF;
    set_wr    = 1'b1;
    adj_value = 64'd1000;
    adj_wr    = 1'b1;
    tick();
    checks++;
    if (stamp_counter !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL set_beats_adj: stamp=%h expected 0123456789ABCDEF", stamp_counter);
    end
  endtask

  task automatic test_adj();
    set_value = 64'd1000;
    set_wr    = 1'b1;
    tick();
    adj_value = -64'sd250;
    adj_wr    = 1'b1;
    tick();
    checks++;
    if (stamp_counter !== 64'd751) begin
      errors++;
      $display("FAIL adj_negative: stamp=%0d expected 751", stamp_counter);
    end
    set_value = 64'd1000;
    set_wr    = 1'b1;
    tick();
    adj_value = 64'd250;
    adj_wr    = 1'b1;
    tick();
    checks++;
    if (stamp_counter !== 64'd1251) begin
      errors++;
      $display("FAIL adj_positive: stamp=%0d expected 1251", stamp_counter);
    end
  endtask

  task automatic test_capture();
    set_value = 64'd500;
    set_wr    = 1'b1;
    tick();
    cap_trig = 4'b0100;
    tick();
    while (m_acc[95:32] != 64'd520) tick();
    cap_trig = 4'b0100;
    tick();
    checks++;
    if (cap_stamp[2*64 +: 64] !== 64'd500 || cap_valid[2] !== 1'b1 || cap_ovf[2] !== 1'b1) begin
      errors++;
      $display("FAIL cap_overflow: stamp=%0d valid=%b ovf=%b expected 500 1 1",
               cap_stamp[2*64 +: 64], cap_valid[2], cap_ovf[2]);
    end
    while (m_acc[95:32] != 64'd530) tick();
    cap_trig = 4'b0100;
    cap_ack  = 4'b0100;
    tick();
    checks++;
    if (cap_stamp[2*64 +: 64] !== 64'd530 || cap_valid[2] !== 1'b1 || cap_ovf[2] !== 1'b0) begin
      errors++;
      $display("FAIL cap_trig_ack: stamp=%0d valid=%b ovf=%b expected 530 1 0",
               cap_stamp[2*64 +: 64], cap_valid[2], cap_ovf[2]);
    end
    cap_ack = 4'b0100;
    tick();
    checks++;
    if (cap_valid[2] !== 1'b0 || cap_ovf[2] !== 1'b0 || cap_stamp[2*64 +: 64] !== 64'd530) begin
      errors++;
      $display("FAIL cap_ack_only: valid=%b ovf=%b stamp=%0d expected 0 0 530",
               cap_valid[2], cap_ovf[2], cap_stamp[2*64 +: 64]);
    end
    checks++;
    if ((cap_valid & 4'b1011) !== 4'b0 || (cap_ovf & 4'b1011) !== 4'b0 ||
        cap_stamp[0 +: 128] !== 128'd0 || cap_stamp[3*64 +: 64] !== 64'd0) begin
      errors++;
      $display("FAIL cap_isolation: valid=%b ovf=%b caps=%h expected other channels zero",
               cap_valid, cap_ovf, cap_stamp);
    end
  endtask

  task automatic test_snapshot();
    int bad;
    bad = 0;
    set_value = 64'h1_0000_0005;
    set_wr    = 1'b1;
    tick();
    snap_req = 1'b1;
    tick();
    for (int k = 0; k < 50; k++) begin
      if (snap_value !== 64'h1_0000_0005) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || snap_value !== 64'h1_0000_0005) begin
      errors++;
      $display("FAIL snapshot_hold: snap=%h expected 0000000100000005 (%0d bad cycles)",
               snap_value, bad);
    end
  endtask

  task automatic test_random();
    logic [NC*64-1:0] exp_caps;
    int bad;
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      incr_wr    = ($urandom_range(0, 15) == 0);
      incr_value = {6'h0, 2'($urandom_range(0, 3)), 32'($urandom)};
      set_wr     = ($urandom_range(0, 19) == 0);
      set_value  = {32'($urandom), 32'($urandom)};
      adj_wr     = ($urandom_range(0, 9) == 0);
      adj_value  = ($urandom_range(0, 1) == 1) ? {32'($urandom), 32'($urandom)}
                                                : 64'($signed(32'($urandom_range(0, 2000))) - 1000);
      cap_trig   = NC'($urandom);
      cap_ack    = NC'($urandom);
      snap_req   = ($urandom_range(0, 7) == 0);
      tick();
      for (int i = 0; i < NC; i++) exp_caps[i*64 +: 64] = m_cap[i];
      if (stamp_counter !== m_acc[95:32] || snap_value !== m_snap || cap_valid !== m_valid ||
          cap_ovf !== m_ovf || cap_stamp !== exp_caps) begin
        bad++;
        if (bad <= 3)
          $display("FAIL random_cycle%0d: stamp=%h/%h snap=%h/%h valid=%b/%b ovf=%b/%b (got/expected)",
                   k, stamp_counter, m_acc[95:32], snap_value, m_snap, cap_valid, m_valid,
                   cap_ovf, m_ovf);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_summary: %0d mismatching cycles, expected 0", bad);
    end
  endtask

  task automatic test_async_reset();
    incr_value = 40'h02_0000_0000;
    incr_wr    = 1'b1;
    cap_trig   = 4'b1111;
    snap_req   = 1'b1;
    tick();
    repeat (5) tick();
    #2;
    axi_resetn = 1'b0;
    #1;
    checks++;
    if (stamp_counter !== 64'd0 || snap_value !== 64'd0 || cap_valid !== '0 ||
        cap_ovf !== '0 || cap_stamp !== '0) begin
      errors++;
      $display("FAIL async_reset: stamp=%h snap=%h valid=%b ovf=%b expected all zero",
               stamp_counter, snap_value, cap_valid, cap_ovf);
    end
    @(posedge clk);
    #1;
    axi_resetn = 1'b1;
    model_reset();
    repeat (10) tick();
    checks++;
    if (stamp_counter !== 64'd10) begin
      errors++;
      $display("FAIL incr_after_reset: stamp=%0d expected 10", stamp_counter);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_adj();
    test_capture();
    test_snapshot();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_osnt_stamp_unit

`default_nettype wire

// File: doc/osnt_stamp_unit.md
Name: osnt_stamp_unit

Overview:
- Second-generation timestamp source for the OSNT datapath.
- Replaces the free-running integer stamp counter with a fixed-point accumulator that software can trim, set and slew.
- Adds NUM_CAPTURE independent capture channels with sticky overflow.
- Adds a coherent snapshot for register readback.
- Sits beside the AXI-lite register block: register writes drive the *_wr strobes, and stamp_counter fans out to the rx/tx stampers.

Parameters:
- TIMESTAMP_WIDTH, 64: integer width of the published stamp.
- FRAC_WIDTH, 32: fractional bits held internally (sub-count precision).
- INC_WIDTH, 40: width of the increment word, unsigned fixed-point with FRAC_WIDTH fraction bits.
- DEFAULT_INCR, 40'h01_0000_0000: increment applied after reset (1.0 per cycle).
- NUM_CAPTURE, 4: number of capture channels, 1..16.

Ports:
- axi_aclk  in  1  clock; all logic on its rising edge.
- axi_resetn  in  1  asynchronous, active-low reset.
- incr_value  in  INC_WIDTH  new per-cycle increment.
- incr_wr  in  1  one-cycle strobe that loads incr_value.
- set_value  in  TIMESTAMP_WIDTH  absolute time to load.
- set_wr  in  1  one-cycle strobe that loads set_value.
- adj_value  in  TIMESTAMP_WIDTH  signed two's-complement one-shot offset.
- adj_wr  in  1  one-cycle strobe that applies adj_value.
- cap_trig  in  NUM_CAPTURE  per-channel capture pulse.
- cap_ack  in  NUM_CAPTURE  per-channel consume/clear.
- cap_stamp  out  NUM_CAPTURE*TIMESTAMP_WIDTH  captured stamps; channel i occupies bits [i*TS +: TS].
- cap_valid  out  NUM_CAPTURE  stamp held, not yet acked.
- cap_ovf  out  NUM_CAPTURE  sticky: a trigger was lost while the channel was valid.
- snap_req  in  1  latch a coherent copy of the counter.
- snap_value  out  TIMESTAMP_WIDTH  latched copy.
- stamp_counter  out  TIMESTAMP_WIDTH  live time, registered.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - accumulator = 0, so stamp_counter = 0.
  - Increment register = DEFAULT_INCR.
  - cap_stamp, cap_valid, cap_ovf and snap_value all 0.
- Accumulator:
  - Width TIMESTAMP_WIDTH+FRAC_WIDTH, unsigned.
  - Arithmetic is modulo 2^(TS+FRAC); wrap-around is silent.
  - stamp_counter = acc[TS+FRAC-1:FRAC], driven straight from the register (no output logic).
- Per-cycle update, first match wins:
  1. set_wr: acc <= {set_value, FRAC zeros}. Any adj_wr in the same cycle is discarded.
  2. adj_wr: acc <= acc + incr + {adj_value, FRAC zeros}. adj_value is sign-extended, so negative values slew backwards.
  3. Otherwise: acc <= acc + incr.
- Increment updates:
  - incr_wr updates the increment register at the clock edge.
  - The new increment takes effect on the following cycle's addition.
  - incr_wr coinciding with set_wr or adj_wr: both actions apply.
  - incr = 0 freezes time (allowed).
- Latency:
  - set_value appears on stamp_counter 1 cycle after set_wr.
  - The adjustment appears 1 cycle after adj_wr.
- Capture channel i (independent registers, no state machine beyond valid/ovf):
  - Value captured is stamp_counter as registered in the cycle cap_trig[i] is high, i.e. pre-update.
  - cap_stamp/cap_valid update 1 cycle later.
  - trig && !valid: stamp <= stamp_counter, valid <= 1.
  - trig && valid && !ack: stamp is held (first event wins), ovf <= 1.
  - trig && ack: stamp <= new value, valid stays 1, ovf <= 0.
  - ack && !trig: valid <= 0, ovf <= 0. Stamp retains its last value.
  - A level held high on cap_trig is treated as a trigger every cycle; upstream must pulse it.
- Snapshot:
  - snap_req: snap_value <= stamp_counter (pre-update) next cycle.
  - snap_value holds until the next snap_req, so software reads the two 32-bit halves coherently.
- Reset asserted mid-operation:
  - All state clears immediately.
  - Pending strobes are lost.
  - The increment reverts to DEFAULT_INCR.

Decomposition:
- Package osnt_stamp_pkg holds:
  - Localparams ACC_WIDTH = TS+FRAC.
  - The default increment constant.
  - A function that sign-extends and shifts adj_value into ACC_WIDTH.
- One sub-module, stamp_capture_chan: a single channel's valid/ovf/stamp logic, generated NUM_CAPTURE times.
- The accumulator and snapshot stay in the top level.

Test Plan:
- Reset, DEFAULT_INCR, run 100 cycles -> stamp_counter = 100; all cap_valid = 0.
- incr_wr with 40'h00_8000_0000 (0.5), run 10 cycles -> stamp advances by 5. Then 40'h01_8000_0000 for 4 cycles -> advances by 6.
- set_wr 64'hFFFF_FFFF_FFFF_FFFE, then 3 cycles at 1.0 -> stamp reads FFFF..FFFF, 0, 1 (wrap). set_wr and adj_wr in the same cycle -> set_value wins exactly.
- At stamp = 1000, adj_wr with -250 -> next cycle stamp = 751. With +250 -> 1251.
- Channel 2 trig at stamp = 500, then trig at 520 without ack -> cap_stamp[2] = 500, valid = 1, ovf = 1. Trig+ack at 530 -> stamp = 530, ovf = 0. Ack alone -> valid = 0. Other channels remain untouched.
- snap_req at stamp = 64'h1_0000_0005 while the counter runs -> snap_value stays 64'h1_0000_0005 for 50 cycles. Assert axi_resetn low mid-run -> all outputs 0 asynchronously.
